// File: rtl/nzcv_flag_unit_pkg.sv
// Shared ALU opcode constants, flag bit positions and class decode for the NZCV unit.
package nzcv_flag_unit_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    localparam logic [3:0] RESET_FLAGS = 4'b0000;

    typedef enum logic [1:0] {
        CLS_LOGIC = 2'd0,
        CLS_ADD   = 2'd1,
        CLS_SUB   = 2'd2,
        CLS_RSUB  = 2'd3
    } alu_class_e;

    // Stage register payload: only the bits the flag logic needs.
    typedef struct packed {
        logic [3:0] op;
        logic       a_msb;
        logic       b_msb;
        logic       r_msb;
        logic       zero;
        logic       alu_c;
        logic       sh_c;
    } stage_t;

    // Map an opcode to the class that selects the C and V rules.
    function automatic alu_class_e alu_class(input logic [3:0] op);
        alu_class_e cls;
        case (op)
            OP_ADD, OP_ADC, OP_CMN: cls = CLS_ADD;
            OP_SUB, OP_SBC, OP_CMP: cls = CLS_SUB;
            OP_RSB, OP_RSC:         cls = CLS_RSUB;
            default:                cls = CLS_LOGIC;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/nzcv_flag_unit_if.sv
// ALU-result / flag bus between execute and the NZCV flag unit.
interface nzcv_flag_unit_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         s_bit;
    logic [3:0]   alu_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] result;
    logic         alu_carry;
    logic         shifter_carry;
    logic         flush;
    logic         exc_entry;
    logic         exc_return;
    logic [3:0]   flags_out;
    logic [3:0]   flags_fwd;
    logic [3:0]   saved_flags;
    logic         update_pending;

    modport master (
        output in_valid, s_bit, alu_op, op_a, op_b, result,
               alu_carry, shifter_carry, flush, exc_entry, exc_return,
        input  flags_out, flags_fwd, saved_flags, update_pending
    );

    modport slave (
        input  in_valid, s_bit, alu_op, op_a, op_b, result,
               alu_carry, shifter_carry, flush, exc_entry, exc_return,
        output flags_out, flags_fwd, saved_flags, update_pending
    );
endinterface

// File: rtl/nzcv_flag_unit_compute.sv
// Combinational NZCV evaluation from the stage register and the current V.
module nzcv_flag_unit_compute
    import nzcv_flag_unit_pkg::*;
(
    input  stage_t     i_stage,
    input  logic       i_old_v,
    output logic [3:0] o_flags_c
);

    alu_class_e w_cls;

    assign w_cls = alu_class(i_stage.op);

    // N/Z straight from the result; C and V chosen by opcode class.
    always_comb begin
        o_flags_c         = 4'b0000;
        o_flags_c[FLAG_N] = i_stage.r_msb;
        o_flags_c[FLAG_Z] = i_stage.zero;
        o_flags_c[FLAG_C] = (w_cls == CLS_LOGIC) ? i_stage.sh_c : i_stage.alu_c;
        case (w_cls)
            CLS_ADD:  o_flags_c[FLAG_V] = (i_stage.a_msb == i_stage.b_msb) &
                                          (i_stage.r_msb != i_stage.a_msb);
            CLS_SUB:  o_flags_c[FLAG_V] = (i_stage.a_msb != i_stage.b_msb) &
                                          (i_stage.r_msb != i_stage.a_msb);
            CLS_RSUB: o_flags_c[FLAG_V] = (i_stage.a_msb != i_stage.b_msb) &
                                          (i_stage.r_msb != i_stage.b_msb);
            default:  o_flags_c[FLAG_V] = i_old_v;
        endcase
    end

endmodule

// File: rtl/nzcv_flag_unit.sv
// NZCV flag producer: one-stage capture, commit, forwarding and exception save/restore.
module nzcv_flag_unit #(
    parameter int unsigned W           = 32,
    parameter logic [3:0]  RESET_FLAGS = nzcv_flag_unit_pkg::RESET_FLAGS
) (
    input  logic              clk,
    input  logic              reset_n,
    nzcv_flag_unit_if.slave   bus
);
    import nzcv_flag_unit_pkg::*;

    stage_t     r_stage;
    logic       r_pending;
    logic [3:0] r_flags;
    logic [3:0] r_saved;

    stage_t     w_stage_d;
    logic [3:0] w_computed;
    logic [3:0] w_fwd;
    logic       w_capture;
    logic       w_commit;

    // A return from exception discards the same-cycle capture as well as the pending one.
    assign w_capture = bus.in_valid & bus.s_bit & ~bus.flush & ~bus.exc_return;
    assign w_commit  = r_pending & ~bus.flush;
    assign w_fwd     = w_commit ? w_computed : r_flags;

    // Fields latched into the stage register on a capture.
    always_comb begin
        w_stage_d       = r_stage;
        w_stage_d.op    = bus.alu_op;
        w_stage_d.a_msb = bus.op_a[W-1];
        w_stage_d.b_msb = bus.op_b[W-1];
        w_stage_d.r_msb = bus.result[W-1];
        w_stage_d.zero  = (bus.result == {W{1'b0}});
        w_stage_d.alu_c = bus.alu_carry;
        w_stage_d.sh_c  = bus.shifter_carry;
    end

    nzcv_flag_unit_compute u_compute (
        .i_stage   (r_stage),
        .i_old_v   (r_flags[FLAG_V]),
        .o_flags_c (w_computed)
    );

    // Stage 1: capture a flag-setting result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_capture;
            if (w_capture) begin
                r_stage <= w_stage_d;
            end
        end
    end

    // Stage 2: commit, with exception return taking priority; entry snapshots the forwarded view.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= RESET_FLAGS;
            r_saved <= 4'b0000;
        end else begin
            if (bus.exc_return) begin
                r_flags <= r_saved;
            end else if (w_commit) begin
                r_flags <= w_computed;
            end
            if (bus.exc_entry) begin
                r_saved <= w_fwd;
            end
        end
    end

    assign bus.flags_out      = r_flags;
    assign bus.flags_fwd      = w_fwd;
    assign bus.saved_flags    = r_saved;
    assign bus.update_pending = r_pending;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Self-checking bench for nzcv_flag_unit: directed scenarios plus randomized traffic vs. a reference model.
module tb_nzcv_flag_unit;
    import nzcv_flag_unit_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    nzcv_flag_unit_if #(.W(W)) bus ();

    nzcv_flag_unit #(.W(W), .RESET_FLAGS(4'b0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         cin;
        logic         ac;
        logic         sc;
    } instr_t;

    instr_t     m_rec;
    logic [3:0] m_flags;
    logic [3:0] m_saved;
    logic       m_pend;
    logic       drv_cin;
    int         checks = 0;
    int         errors = 0;

    // Reference flags from full-width signed arithmetic on the instruction.
    function automatic logic [3:0] ref_eval(input instr_t t, input logic old_v);
        longint sa, sb, sr, ex, brw;
        logic n, z, c, v;
        int cls;
        sa  = longint'($signed(t.a));
        sb  = longint'($signed(t.b));
        sr  = longint'($signed(t.r));
        brw = t.cin ? 0 : 1;
        case (t.op)
            4'd4, 4'd5, 4'd11: cls = 1;
            4'd2, 4'd6, 4'd10: cls = 2;
            4'd3, 4'd7:        cls = 3;
            default:           cls = 0;
        endcase
        n = t.r[W-1];
        z = (t.r == '0);
        c = (cls == 0) ? t.sc : t.ac;
        case (cls)
            1: begin ex = sa + sb + (t.cin ? 1 : 0); v = (ex != sr); end
            2: begin ex = sa - sb - brw;             v = (ex != sr); end
            3: begin ex = sb - sa - brw;             v = (ex != sr); end
            default: v = old_v;
        endcase
        return {n, z, c, v};
    endfunction

    function automatic logic [3:0] model_fwd();
        return (m_pend && !bus.flush) ? ref_eval(m_rec, m_flags[0]) : m_flags;
    endfunction

    task automatic set_instr(input logic v, input logic s, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                             input logic cin, input logic ac, input logic sc);
        bus.in_valid      = v;
        bus.s_bit         = s;
        bus.alu_op        = op;
        bus.op_a          = a;
        bus.op_b          = b;
        bus.result        = r;
        bus.alu_carry     = ac;
        bus.shifter_carry = sc;
        drv_cin           = cin;
    endtask

    task automatic clear_inputs();
        set_instr(1'b0, 1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.flush      = 1'b0;
        bus.exc_entry  = 1'b0;
        bus.exc_return = 1'b0;
    endtask

    // One clock: advance the reference model with the inputs presented this cycle.
    task automatic tick();
        logic [3:0] fwd, nf, ns;
        logic       np;
        instr_t     nrec;
        fwd = model_fwd();
        ns  = bus.exc_entry ? fwd : m_saved;
        nf  = bus.exc_return ? m_saved : fwd;
        np  = bus.in_valid & bus.s_bit & ~bus.flush & ~bus.exc_return;
        nrec.op = bus.alu_op; nrec.a = bus.op_a; nrec.b = bus.op_b; nrec.r = bus.result;
        nrec.cin = drv_cin; nrec.ac = bus.alu_carry; nrec.sc = bus.shifter_carry;
        @(posedge clk);
        m_flags = nf;
        m_saved = ns;
        m_pend  = np;
        if (np) m_rec = nrec;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_saved = 4'b0000;
        m_pend  = 1'b0;
        m_rec   = '{op: 4'd0, a: '0, b: '0, r: '0, cin: 1'b0, ac: 1'b0, sc: 1'b0};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        checks++;
        if (bus.flags_out !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", bus.flags_out); end
        checks++;
        if (bus.saved_flags !== 4'b0000) begin errors++; $display("FAIL reset_saved got %b exp 0000", bus.saved_flags); end
        checks++;
        if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", bus.update_pending); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        set_instr(1'b1, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.flags_fwd !== 4'b1001) begin errors++; $display("FAIL add_ovf_fwd got %b exp 1001", bus.flags_fwd); end
        checks++;
        if (bus.flags_out !== 4'b0000) begin errors++; $display("FAIL add_ovf_out_early got %b exp 0000", bus.flags_out); end
        tick();
        checks++;
        if (bus.flags_out !== 4'b1001) begin errors++; $display("FAIL add_ovf_out got %b exp 1001", bus.flags_out); end
    endtask

    task automatic test_cmp_mov();
        set_instr(1'b1, 1'b1, OP_CMP, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 1'b1, OP_MOV, 32'd0, 32'hF000_0000, 32'hF000_0000, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.flags_fwd !== 4'b0110) begin errors++; $display("FAIL cmp_fwd got %b exp 0110", bus.flags_fwd); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.flags_out !== 4'b0110) begin errors++; $display("FAIL cmp_out got %b exp 0110", bus.flags_out); end
        checks++;
        if (bus.flags_fwd !== 4'b1000 || bus.update_pending !== 1'b1) begin
            errors++; $display("FAIL mov_fwd got %b/%b exp 1000/1", bus.flags_fwd, bus.update_pending);
        end
        tick();
        checks++;
        if (bus.flags_out !== 4'b1000) begin errors++; $display("FAIL mov_out got %b exp 1000", bus.flags_out); end
    endtask

    task automatic test_flush();
        set_instr(1'b1, 1'b1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        clear_inputs();
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.flags_fwd !== 4'b1000) begin errors++; $display("FAIL flush_fwd got %b exp 1000", bus.flags_fwd); end
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.flags_out !== 4'b1000 || bus.update_pending !== 1'b0) begin
            errors++; $display("FAIL flush_out got %b/%b exp 1000/0", bus.flags_out, bus.update_pending);
        end
    endtask

    task automatic test_sbit0();
        set_instr(1'b1, 1'b0, OP_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        checks++;
        if (bus.flags_out !== 4'b1000 || bus.flags_fwd !== 4'b1000 || bus.update_pending !== 1'b0) begin
            errors++; $display("FAIL sbit0 got out %b fwd %b pend %b exp 1000 1000 0",
                               bus.flags_out, bus.flags_fwd, bus.update_pending);
        end
        clear_inputs();
    endtask

    task automatic test_exception();
        set_instr(1'b1, 1'b1, OP_MOV, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        tick();
        clear_inputs();
        tick();
        checks++;
        if (bus.flags_out !== 4'b0010) begin errors++; $display("FAIL exc_setup got %b exp 0010", bus.flags_out); end
        set_instr(1'b1, 1'b1, OP_CMN, 32'hF000_0000, 32'h0100_0000, 32'hF100_0000, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        bus.exc_entry = 1'b1;
        #1;
        checks++;
        if (bus.flags_fwd !== 4'b1000) begin errors++; $display("FAIL exc_entry_fwd got %b exp 1000", bus.flags_fwd); end
        tick();
        bus.exc_entry = 1'b0;
        checks++;
        if (bus.saved_flags !== 4'b1000 || bus.flags_out !== 4'b1000) begin
            errors++; $display("FAIL exc_entry got saved %b out %b exp 1000 1000", bus.saved_flags, bus.flags_out);
        end
        set_instr(1'b1, 1'b1, OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        tick();
        checks++;
        if (bus.flags_out !== 4'b0100) begin errors++; $display("FAIL exc_mid got %b exp 0100", bus.flags_out); end
        set_instr(1'b1, 1'b1, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        tick();
        set_instr(1'b1, 1'b1, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        bus.exc_return = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (bus.flags_out !== 4'b1000 || bus.update_pending !== 1'b0) begin
            errors++; $display("FAIL exc_return got %b/%b exp 1000/0", bus.flags_out, bus.update_pending);
        end
        tick();
        checks++;
        if (bus.flags_out !== 4'b1000) begin errors++; $display("FAIL exc_return_hold got %b exp 1000", bus.flags_out); end
    endtask

    task automatic test_swap();
        set_instr(1'b1, 1'b1, OP_AND, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        tick();
        bus.exc_entry  = 1'b1;
        bus.exc_return = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (bus.flags_out !== 4'b1000 || bus.saved_flags !== 4'b0100) begin
            errors++; $display("FAIL swap got out %b saved %b exp 1000 0100", bus.flags_out, bus.saved_flags);
        end
    endtask

    // Consistent random ALU transaction: carries and result agree with the opcode's arithmetic.
    task automatic gen_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, r;
        logic [W:0]   sum;
        logic         cin, ac, sc;
        op  = 4'($urandom_range(0, 15));
        a   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        b   = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
        sc  = 1'($urandom_range(0, 1));
        ac  = 1'($urandom_range(0, 1));
        cin = 1'b0;
        r   = W'($urandom);
        case (op)
            OP_ADD, OP_CMN: begin cin = 1'b0; sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin); {ac, r} = sum; end
            OP_ADC:         begin cin = 1'($urandom_range(0, 1)); sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin); {ac, r} = sum; end
            OP_SUB, OP_CMP: begin cin = 1'b1; sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin); {ac, r} = sum; end
            OP_SBC:         begin cin = 1'($urandom_range(0, 1)); sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin); {ac, r} = sum; end
            OP_RSB:         begin cin = 1'b1; sum = {1'b0, b} + {1'b0, ~a} + (W+1)'(cin); {ac, r} = sum; end
            OP_RSC:         begin cin = 1'($urandom_range(0, 1)); sum = {1'b0, b} + {1'b0, ~a} + (W+1)'(cin); {ac, r} = sum; end
            default:        if ($urandom_range(0, 3) == 0) r = '0;
        endcase
        set_instr(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7), op, a, b, r, cin, ac, sc);
        bus.flush      = ($urandom_range(0, 9) == 0);
        bus.exc_entry  = ($urandom_range(0, 15) == 0);
        bus.exc_return = ($urandom_range(0, 15) == 0);
    endtask

    task automatic test_random();
        logic [3:0] exp_fwd;
        for (int i = 0; i < 400; i++) begin
            gen_random();
            #1;
            exp_fwd = model_fwd();
            checks++;
            if (bus.flags_fwd !== exp_fwd) begin
                errors++; $display("FAIL rand_fwd cyc %0d got %b exp %b", i, bus.flags_fwd, exp_fwd);
            end
            tick();
            checks++;
            if (bus.flags_out !== m_flags || bus.saved_flags !== m_saved || bus.update_pending !== m_pend) begin
                errors++;
                $display("FAIL rand_state cyc %0d got out %b saved %b pend %b exp %b %b %b",
                         i, bus.flags_out, bus.saved_flags, bus.update_pending, m_flags, m_saved, m_pend);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_midrun();
        set_instr(1'b1, 1'b1, OP_SUB, 32'd4, 32'd4, 32'd0, 1'b1, 1'b1, 1'b0);
        bus.exc_entry = 1'b1;
        tick();
        clear_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.flags_out !== 4'b0000 || bus.update_pending !== 1'b0 || bus.saved_flags !== 4'b0000) begin
            errors++; $display("FAIL reset_mid got out %b pend %b saved %b exp 0000 0 0000",
                               bus.flags_out, bus.update_pending, bus.saved_flags);
        end
        checks++;
        if (bus.flags_fwd !== 4'b0000) begin errors++; $display("FAIL reset_mid_fwd got %b exp 0000", bus.flags_fwd); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_cmp_mov();
        test_flush();
        test_sbit0();
        test_exception();
        test_swap();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
